// File: rtl/puf_fe_pkg.sv
// Shared types and constants for the PUF fuzzy-extractor helper-data generator.
package puf_fe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUF_FETCH,
        ST_TRNG_FETCH,
        ST_STREAM,
        ST_DONE
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_PUF_TO = 2'd1;
    localparam logic [1:0] ERR_TRNG   = 2'd2;
    localparam logic [1:0] ERR_ABORT  = 2'd3;

    localparam logic MODE_REP  = 1'b0;
    localparam logic MODE_FULL = 1'b1;

endpackage

// File: rtl/puf_helper_stream_gen_if.sv
// Helper-data stream bus: valid/ready handshake with an end-of-run marker.
interface puf_helper_stream_gen_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] hd_data;
    logic             hd_valid;
    logic             hd_ready;
    logic             hd_last;

    modport master (output hd_data, output hd_valid, output hd_last, input hd_ready);
    modport slave  (input hd_data, input hd_valid, input hd_last, output hd_ready);
endinterface

// File: rtl/rm1_encoder.sv
// Combinational first-order Reed-Muller encoder: K = M+1 message bits to N = 2**M code bits.
module rm1_encoder #(
    parameter  int M = 5,
    localparam int N = 2 ** M,
    localparam int K = M + 1
) (
    input  logic [K-1:0] msg,
    output logic [N-1:0] cw
);

    // Bit u is the affine function a0 ^ <a[M:1], u> evaluated at point u.
    always_comb begin
        cw = '0;
        for (int u = 0; u < N; u++) begin
            cw[u] = msg[0] ^ (^(msg[K-1:1] & M'(u)));
        end
    end

endmodule

// File: rtl/puf_helper_stream_gen.sv
// Fuzzy-extractor enrollment: fetch PUF bytes, collect TRNG secret, stream RM-coded helper data.
module puf_helper_stream_gen
    import puf_fe_pkg::*;
#(
    parameter  int PUF_BLOCKS = 2,
    parameter  int BLOCKS     = 22,
    parameter  int M          = 5,
    parameter  int OUT_W      = 8,
    parameter  int TIMEOUT    = 255,
    parameter  int RUN_MAX    = 16,
    localparam int N          = 2 ** M,
    localparam int K          = M + 1,
    localparam int PUF_BYTES  = PUF_BLOCKS * N / 8,
    localparam int ADDR_W     = (PUF_BYTES > 1) ? $clog2(PUF_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  abort,
    output logic                  puf_req,
    output logic [ADDR_W-1:0]     puf_addr,
    input  logic [7:0]            puf_data,
    input  logic                  puf_valid,
    output logic                  trng_req,
    input  logic                  trng_data,
    input  logic                  trng_valid,
    puf_helper_stream_gen_if.master hd,
    output logic [BLOCKS*K-1:0]   key_data,
    output logic                  key_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int WPB    = N / OUT_W;
    localparam int TBITS  = BLOCKS * K;
    localparam int TCNT_W = $clog2(TBITS + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int RUN_W  = $clog2(RUN_MAX + 1);
    localparam int SUB_W  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int PB_W   = (PUF_BLOCKS > 1) ? $clog2(PUF_BLOCKS) : 1;

    if (N % OUT_W != 0) begin : g_bad_out_w
        $error("OUT_W must divide the code length N");
    end

    state_t                  state;
    logic                    mode_q;
    logic [PUF_BLOCKS*N-1:0] puf_q;
    logic [BLOCKS*K-1:0]     x_q;
    logic [TCNT_W-1:0]       tcnt;
    logic [TCNT_W-1:0]       tbits_needed;
    logic [TO_W-1:0]         to_cnt;
    logic [RUN_W-1:0]        run_cnt;
    logic [RUN_W-1:0]        run_next;
    logic                    last_bit;
    logic [BLK_W-1:0]        blk;
    logic [SUB_W-1:0]        sub;
    logic [PB_W-1:0]         pblk;
    logic [K-1:0]            enc_in;
    logic [N-1:0]            enc_cw;
    logic [N-1:0]            helper;
    logic [OUT_W-1:0]        word;
    logic                    fail;
    logic [1:0]              fail_code;

    rm1_encoder #(.M(M)) u_enc (
        .msg (enc_in),
        .cw  (enc_cw)
    );

    assign enc_in       = x_q[blk*K +: K];
    assign helper       = puf_q[pblk*N +: N] ^ enc_cw;
    assign word         = helper[sub*OUT_W +: OUT_W];
    assign tbits_needed = (mode_q == MODE_FULL) ? TCNT_W'(TBITS) : TCNT_W'(BLOCKS);
    assign run_next     = (tcnt == '0 || trng_data != last_bit) ? RUN_W'(1) : run_cnt + 1'b1;
    assign key_data     = x_q;
    assign busy         = (state != ST_IDLE);

    // Failure detection; abort overrides any timeout or health verdict in the same cycle.
    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_NONE;
        case (state)
            ST_PUF_FETCH: begin
                if (!puf_valid && to_cnt == TO_W'(TIMEOUT - 1)) begin
                    fail      = 1'b1;
                    fail_code = ERR_PUF_TO;
                end
            end
            ST_TRNG_FETCH: begin
                if (trng_valid ? (run_next == RUN_W'(RUN_MAX)) : (to_cnt == TO_W'(TIMEOUT - 1))) begin
                    fail      = 1'b1;
                    fail_code = ERR_TRNG;
                end
            end
            default: ;
        endcase
        if (abort && state != ST_IDLE) begin
            fail      = 1'b1;
            fail_code = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_REP;
            puf_q       <= '0;
            x_q         <= '0;
            tcnt        <= '0;
            to_cnt      <= '0;
            run_cnt     <= '0;
            last_bit    <= 1'b0;
            blk         <= '0;
            sub         <= '0;
            pblk        <= '0;
            puf_req     <= 1'b0;
            puf_addr    <= '0;
            trng_req    <= 1'b0;
            hd.hd_data  <= '0;
            hd.hd_valid <= 1'b0;
            hd.hd_last  <= 1'b0;
            key_valid   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (fail) begin
                state       <= ST_IDLE;
                puf_req     <= 1'b0;
                trng_req    <= 1'b0;
                hd.hd_data  <= '0;
                hd.hd_valid <= 1'b0;
                hd.hd_last  <= 1'b0;
                key_valid   <= 1'b0;
                x_q         <= '0;
                puf_q       <= '0;
                error       <= 1'b1;
                err_code    <= fail_code;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state     <= ST_PUF_FETCH;
                            mode_q    <= mode;
                            puf_req   <= 1'b1;
                            puf_addr  <= '0;
                            to_cnt    <= '0;
                            key_valid <= 1'b0;
                            err_code  <= ERR_NONE;
                        end
                    end
                    ST_PUF_FETCH: begin
                        if (puf_valid) begin
                            puf_q[puf_addr*8 +: 8] <= puf_data;
                            to_cnt <= '0;
                            if (puf_addr == ADDR_W'(PUF_BYTES - 1)) begin
                                state    <= ST_TRNG_FETCH;
                                puf_req  <= 1'b0;
                                trng_req <= 1'b1;
                                tcnt     <= '0;
                                run_cnt  <= '0;
                            end else begin
                                puf_addr <= puf_addr + 1'b1;
                            end
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    ST_TRNG_FETCH: begin
                        if (trng_valid) begin
                            to_cnt   <= '0;
                            tcnt     <= tcnt + 1'b1;
                            run_cnt  <= run_next;
                            last_bit <= trng_data;
                            if (mode_q == MODE_FULL) begin
                                x_q[tcnt] <= trng_data;
                            end else begin
                                x_q[tcnt*K +: K] <= {K{trng_data}};
                            end
                            if (tcnt == tbits_needed - 1'b1) begin
                                state       <= ST_STREAM;
                                trng_req    <= 1'b0;
                                blk         <= '0;
                                sub         <= '0;
                                pblk        <= '0;
                                hd.hd_valid <= 1'b0;
                            end
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    // A word is reloaded whenever the output slot is empty or being consumed.
                    ST_STREAM: begin
                        if (hd.hd_valid && hd.hd_ready && hd.hd_last) begin
                            state       <= ST_DONE;
                            hd.hd_valid <= 1'b0;
                            hd.hd_last  <= 1'b0;
                            done        <= 1'b1;
                            key_valid   <= 1'b1;
                        end else if (!hd.hd_valid || hd.hd_ready) begin
                            hd.hd_data  <= word;
                            hd.hd_valid <= 1'b1;
                            hd.hd_last  <= (blk == BLK_W'(BLOCKS - 1)) && (sub == SUB_W'(WPB - 1));
                            if (sub == SUB_W'(WPB - 1)) begin
                                sub  <= '0;
                                blk  <= blk + 1'b1;
                                pblk <= (pblk == PB_W'(PUF_BLOCKS - 1)) ? '0 : pblk + 1'b1;
                            end else begin
                                sub <= sub + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
